// File: rtl/gpio_arbiter.sv
// Two-requester round-robin arbiter onto a single GPIO register bus (IDLE/ACCESS/RESP).
// Optional ACCESS timeout is built in when GPIO_ARB_TIMEOUT_EN is defined.
module gpio_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        s0_valid,
    input  logic [3:0]  s0_addr,
    input  logic [3:0]  s0_wrstb,
    input  logic [31:0] s0_wdata,
    output logic        s0_ready,
    output logic [31:0] s0_rdata,
    input  logic        s1_valid,
    input  logic [3:0]  s1_addr,
    input  logic [3:0]  s1_wrstb,
    input  logic [31:0] s1_wdata,
    output logic        s1_ready,
    output logic [31:0] s1_rdata,
    output logic        m_valid,
    output logic [3:0]  m_addr,
    output logic [3:0]  m_wrstb,
    output logic [31:0] m_wdata,
    input  logic        m_ready,
    input  logic [31:0] m_rdata,
    output logic        timeout
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t      state_q, state_d;
    logic        grant_q;
    logic        last_q;
    logic        pick;
    logic        req_any;
    logic        req_both;
    logic        expire;
    logic [31:0] rdata_q;

    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_param_check
        $error("gpio_arbiter: TIMEOUT_CYCLES must be in 2..255");
    end

    assign req_any  = s0_valid | s1_valid;
    assign req_both = s0_valid & s1_valid;
    // Contention goes to the side that lost the previous contention; a lone request just wins.
    assign pick     = req_both ? ~last_q : s1_valid;

`ifdef GPIO_ARB_TIMEOUT_EN
    logic [7:0] cnt_q;
    logic       to_q;

    assign expire = (state_q == ACCESS) && !m_ready &&
                    (cnt_q == 8'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (state_q == IDLE) begin
            cnt_q <= '0;
        end else if (state_q == ACCESS) begin
            cnt_q <= cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            to_q <= 1'b0;
        end else if (state_q == ACCESS) begin
            to_q <= expire;
        end
    end
`else
    assign expire = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req_any) state_d = ACCESS;
            ACCESS:  if (m_ready || expire) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            m_valid <= 1'b0;
            m_addr  <= '0;
            m_wrstb <= '0;
            m_wdata <= '0;
            grant_q <= 1'b0;
            last_q  <= 1'b1;
            rdata_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_any) begin
                        grant_q <= pick;
                        if (req_both) last_q <= pick;
                        m_valid <= 1'b1;
                        m_addr  <= pick ? s1_addr  : s0_addr;
                        m_wrstb <= pick ? s1_wrstb : s0_wrstb;
                        m_wdata <= pick ? s1_wdata : s0_wdata;
                    end
                end
                ACCESS: begin
                    if (m_ready || expire) begin
                        m_valid <= 1'b0;
                        rdata_q <= m_ready ? m_rdata : 32'hDEAD_BEEF;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        s0_ready = (state_q == RESP) && !grant_q;
        s1_ready = (state_q == RESP) && grant_q;
        s0_rdata = s0_ready ? rdata_q : '0;
        s1_rdata = s1_ready ? rdata_q : '0;
`ifdef GPIO_ARB_TIMEOUT_EN
        timeout  = (state_q == RESP) && to_q;
`else
        timeout  = 1'b0;
`endif
    end

endmodule

// File: tb/tb_gpio_arbiter.sv
// Directed bench for gpio_arbiter: GPIO register slave model plus per-requester
// response scoreboard checked whenever an s*_ready pulse appears.
module tb_gpio_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        s0_valid, s1_valid;
    logic [3:0]  s0_addr, s1_addr, s0_wrstb, s1_wrstb;
    logic [31:0] s0_wdata, s1_wdata;
    logic        s0_ready, s1_ready;
    logic [31:0] s0_rdata, s1_rdata;
    logic        m_valid;
    logic [3:0]  m_addr, m_wrstb;
    logic [31:0] m_wdata;
    logic        m_ready;
    logic [31:0] m_rdata;
    logic        timeout;

    logic        slave_mute;
    logic [31:0] pins;
    logic [31:0] regs [16];

    typedef struct packed {
        logic [31:0] rdata;
        logic        to;
    } exp_t;

    exp_t exp0[$];
    exp_t exp1[$];
    int   served_id[$];
    int   served_cyc[$];
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    gpio_arbiter #(.TIMEOUT_CYCLES(16)) dut (
        .clk      (clk),
        .reset    (reset),
        .s0_valid (s0_valid),
        .s0_addr  (s0_addr),
        .s0_wrstb (s0_wrstb),
        .s0_wdata (s0_wdata),
        .s0_ready (s0_ready),
        .s0_rdata (s0_rdata),
        .s1_valid (s1_valid),
        .s1_addr  (s1_addr),
        .s1_wrstb (s1_wrstb),
        .s1_wdata (s1_wdata),
        .s1_ready (s1_ready),
        .s1_rdata (s1_rdata),
        .m_valid  (m_valid),
        .m_addr   (m_addr),
        .m_wrstb  (m_wrstb),
        .m_wdata  (m_wdata),
        .m_ready  (m_ready),
        .m_rdata  (m_rdata),
        .timeout  (timeout)
    );

    // Downstream GPIO registers: ready one registered cycle after m_valid; addr 8 reads pins.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_ready <= 1'b0;
            m_rdata <= '0;
            for (int i = 0; i < 16; i++) regs[i] <= '0;
        end else begin
            m_ready <= m_valid & ~slave_mute;
            if (m_valid && !m_ready && !slave_mute) begin
                if (m_wrstb != 4'h0) begin
                    for (int b = 0; b < 4; b++)
                        if (m_wrstb[b]) regs[m_addr][8*b +: 8] <= m_wdata[8*b +: 8];
                    m_rdata <= '0;
                end else begin
                    m_rdata <= (m_addr == 4'd8) ? pins : regs[m_addr];
                end
            end
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (reset !== 1'b1) begin
            if (s0_ready || s1_ready) begin
                int   id;
                exp_t e;
                chk("one_ready", {31'd0, s0_ready & s1_ready}, 32'd0);
                id = s1_ready ? 1 : 0;
                chk("resp_expected", (id == 0) ? exp0.size() : exp1.size(), 32'd1);
                if ((id == 0 && exp0.size() > 0) || (id == 1 && exp1.size() > 0)) begin
                    e = (id == 0) ? exp0.pop_front() : exp1.pop_front();
                    chk(id == 0 ? "s0_rdata" : "s1_rdata", id == 0 ? s0_rdata : s1_rdata, e.rdata);
                    chk("timeout_flag", {31'd0, timeout}, {31'd0, e.to});
                    chk("other_rdata", id == 0 ? s1_rdata : s0_rdata, 32'd0);
                end
                served_id.push_back(id);
                served_cyc.push_back(cyc);
            end else begin
                chk("idle_rdata", s0_rdata | s1_rdata, 32'd0);
                chk("idle_timeout", {31'd0, timeout}, 32'd0);
            end
        end
    end

    task automatic req(input int id, input logic [3:0] addr, input logic [3:0] st,
                       input logic [31:0] wd, input int budget, output int lat);
        if (id == 0) begin
            s0_addr = addr; s0_wrstb = st; s0_wdata = wd; s0_valid = 1'b1;
        end else begin
            s1_addr = addr; s1_wrstb = st; s1_wdata = wd; s1_valid = 1'b1;
        end
        lat = 0;
        for (int c = 1; c <= budget; c++) begin
            @(negedge clk);
            if ((id == 0) ? s0_ready : s1_ready) begin
                lat = c;
                break;
            end
            @(posedge clk); #1;
        end
        if (lat != 0) begin
            @(posedge clk); #1;
        end
        if (id == 0) s0_valid = 1'b0;
        else         s1_valid = 1'b0;
    endtask

    initial begin
        #200us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, lat_b, n;
        reset = 1'b1;
        s0_valid = 1'b0; s1_valid = 1'b0;
        s0_addr = '0; s1_addr = '0; s0_wrstb = '0; s1_wrstb = '0;
        s0_wdata = '0; s1_wdata = '0;
        slave_mute = 1'b0;
        pins = 32'h0000_003C;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ctrl", {22'd0, m_valid, s0_ready, s1_ready, timeout, m_addr, m_wrstb}, 32'd0);
        chk("rst_wdata", m_wdata, 32'd0);
        chk("rst_rdata", s0_rdata | s1_rdata, 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        // Single write, then read back the output register
        exp0.push_back('{rdata: 32'd0, to: 1'b0});
        fork
            req(0, 4'd4, 4'hF, 32'h0000_00A5, 20, lat);
            begin
                @(posedge clk); #1;
                chk("wr_m_valid", {31'd0, m_valid}, 32'd1);
                chk("wr_m_addr", {28'd0, m_addr}, 32'd4);
                chk("wr_m_wrstb", {28'd0, m_wrstb}, 32'hF);
                chk("wr_m_wdata", m_wdata, 32'h0000_00A5);
            end
        join
        chk("wr_latency", lat, 32'd4);
        exp0.push_back('{rdata: 32'h0000_00A5, to: 1'b0});
        req(0, 4'd4, 4'h0, 32'd0, 20, lat);
        chk("rd4_latency", lat, 32'd4);

        // Simultaneous pair: s0 first, s1 one IDLE later
        n = served_id.size();
        exp0.push_back('{rdata: 32'd0, to: 1'b0});
        exp1.push_back('{rdata: 32'd0, to: 1'b0});
        fork
            req(0, 4'd1, 4'hF, 32'h1111_0011, 30, lat);
            req(1, 4'd2, 4'h3, 32'hFFFF_2222, 30, lat_b);
        join
        chk("pair1_first", served_id[n], 32'd0);
        chk("pair1_second", served_id[n+1], 32'd1);
        chk("pair1_gap", 32'(served_cyc[n+1] - served_cyc[n]), 32'd4);

        // Second pair: s1 wins this contention
        n = served_id.size();
        exp0.push_back('{rdata: 32'h1111_0011, to: 1'b0});
        exp1.push_back('{rdata: 32'h0000_2222, to: 1'b0});
        fork
            req(0, 4'd1, 4'h0, 32'd0, 30, lat);
            req(1, 4'd2, 4'h0, 32'd0, 30, lat_b);
        join
        chk("pair2_first", served_id[n], 32'd1);
        chk("pair2_second", served_id[n+1], 32'd0);

        // Pin read with a stale m_ready during RESP
        exp1.push_back('{rdata: 32'h0000_003C, to: 1'b0});
        req(1, 4'd8, 4'h0, 32'd0, 20, lat);
        chk("pin_latency", lat, 32'd4);
        n = served_id.size();
        repeat (4) begin
            @(negedge clk);
            chk("stale_no_grant", {31'd0, m_valid}, 32'd0);
        end
        chk("stale_no_pulse", served_id.size(), n);

        // Reset in the middle of ACCESS
        @(posedge clk); #1;
        s0_addr = 4'd3; s0_wrstb = 4'h0; s0_wdata = '0; s0_valid = 1'b1;
        @(posedge clk); #1;
        chk("mid_m_valid", {31'd0, m_valid}, 32'd1);
        @(posedge clk); #2;
        reset = 1'b1;
        #1;
        chk("mid_rst_ctrl", {22'd0, m_valid, s0_ready, s1_ready, timeout, m_addr, m_wrstb}, 32'd0);
        chk("mid_rst_wdata", m_wdata, 32'd0);
        chk("mid_rst_rdata", s0_rdata | s1_rdata, 32'd0);
        s0_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        n = served_id.size();
        repeat (6) @(posedge clk);
        #1;
        chk("mid_no_ready", served_id.size(), n);
        exp0.push_back('{rdata: 32'd0, to: 1'b0});
        exp1.push_back('{rdata: 32'd0, to: 1'b0});
        fork
            req(0, 4'd5, 4'hF, 32'h5555_5555, 30, lat);
            req(1, 4'd6, 4'hF, 32'h6666_6666, 30, lat_b);
        join
        chk("post_rst_first", served_id[n], 32'd0);

        // Downstream never responds
        slave_mute = 1'b1;
`ifdef GPIO_ARB_TIMEOUT_EN
        exp0.push_back('{rdata: 32'hDEAD_BEEF, to: 1'b1});
        req(0, 4'd5, 4'h0, 32'd0, 40, lat);
        chk("to_latency", lat, 32'd18);
`else
        req(0, 4'd5, 4'h0, 32'd0, 40, lat);
        chk("no_to_ready", lat, 32'd0);
        chk("no_to_still_waiting", {31'd0, m_valid}, 32'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
`endif
        slave_mute = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_empty", exp0.size() + exp1.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
